hw5_alu_arbiter: RTL



---
 rtl/hw5_alu_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/hw5_alu_arbiter.sv
// Round-robin two-requester sequencer for the hw5 ALU.
// Registers operands, captures the ALU result, and pulses the owner's response.
module hw5_alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             busy,
  output logic [WIDTH-1:0] aluin1,
  output logic [WIDTH-1:0] aluin2,
  output logic [1:0]       alu_control,
  input  logic [WIDTH-1:0] aluout,
  input  logic             alu_carry
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state_q;
  logic             last_q;
  logic             owner_q;
  logic             busy_q;
  logic             rsp0_q;
  logic             rsp1_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       op_q;
  logic             idle;
  logic             win1;
  logic             acc;

  // Requester 1 wins when alone, or on contention after a grant to 0.
  assign idle = (state_q == IDLE) & ~rst;
  assign win1 = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = idle & req0_valid & ~win1;
  assign req1_ready = idle & win1;
  assign acc = req0_ready | req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      op_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rsp0_q <= 1'b0;
          rsp1_q <= 1'b0;
          if (acc) begin
            a_q     <= win1 ? req1_a : req0_a;
            b_q     <= win1 ? req1_b : req0_b;
            op_q    <= win1 ? req1_op : req0_op;
            owner_q <= win1;
            last_q  <= win1;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          data_q  <= aluout;
          carry_q <= alu_carry;
          rsp0_q  <= ~owner_q;
          rsp1_q  <= owner_q;
          state_q <= RESP;
        end
        RESP: begin
          rsp0_q  <= 1'b0;
          rsp1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A reset landing in RESP suppresses the pulse already on the wire.
  assign rsp0_valid  = rsp0_q & ~rst;
  assign rsp1_valid  = rsp1_q & ~rst;
  assign rsp_data    = data_q;
  assign rsp_carry   = carry_q;
  assign busy        = busy_q;
  assign aluin1      = a_q;
  assign aluin2      = b_q;
  assign alu_control = op_q;

endmodule
